// File: rtl/axi_sram_read_slave_if.sv
// AXI4 read address and read data channels between the read arbiter and the SRAM responder.
interface axi_sram_read_slave_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/axi_sram_read_slave.sv
// AXI4 read responder over a 64-bit SRAM: one AR at a time, FIXED/INCR/WRAP bursts,
// programmable first-beat latency, per-beat range checking and a side-door preload port.
module axi_sram_read_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    axi_sram_read_slave_if.slave        bus,
    input  logic                        mem_we,
    input  logic [31:0]                 mem_waddr,
    input  logic [63:0]                 mem_wdata,
    input  logic [7:0]                  mem_wstrb
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t             state, state_d;
    logic [63:0]        mem [DEPTH];

    logic [31:0]        addr, addr_d, addr_next;
    logic [3:0]         id, id_d;
    logic [7:0]         len, len_d, beat, beat_d;
    logic [2:0]         size, size_d;
    logic [1:0]         burst, burst_d;
    logic               slverr, slverr_d;
    logic [LAT_W-1:0]   lat, lat_d;

    logic               arready, arready_d;
    logic               rvalid, rvalid_d;
    logic               rlast, rlast_d;
    logic [1:0]         rresp, rresp_d;
    logic [63:0]        rdata, rdata_d;
    logic [3:0]         rid, rid_d;

    logic [31:0]        req_mask, step, wrap_mask, rd_off, wr_off;
    logic               req_slverr, present, rd_hit, wr_hit;
    logic [IDX_W-1:0]   rd_idx, wr_idx;

    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rlast   = rlast;
    assign bus.rresp   = rresp;
    assign bus.rdata   = rdata;
    assign bus.rid     = rid;

    // Illegal request shapes poison every beat of the burst with SLVERR.
    always_comb begin
        req_mask   = (32'd1 << bus.arsize) - 32'd1;
        req_slverr = (bus.arsize > 3'd3) || (bus.arburst == 2'b11)
                  || ((bus.arburst == BURST_WRAP) && !(bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  || ((bus.arburst == BURST_WRAP) && ((bus.araddr & req_mask) != 32'd0));
    end

    // Address of the beat following the one currently presented.
    always_comb begin
        step      = 32'd1 << size;
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        unique case (burst)
            BURST_FIXED: addr_next = addr;
            BURST_WRAP:  addr_next = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     addr_next = addr + step;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state;
        addr_d   = addr;
        id_d     = id;
        len_d    = len;
        size_d   = size;
        burst_d  = burst;
        slverr_d = slverr;
        beat_d   = beat;
        lat_d    = lat;
        rvalid_d = rvalid;
        rlast_d  = rlast;
        rresp_d  = rresp;
        rdata_d  = rdata;
        rid_d    = rid;
        present  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.arvalid && arready) begin
                    addr_d   = bus.araddr;
                    id_d     = bus.arid;
                    len_d    = bus.arlen;
                    size_d   = bus.arsize;
                    burst_d  = bus.arburst;
                    slverr_d = req_slverr;
                    beat_d   = 8'd0;
                    lat_d    = LAT_W'(LATENCY - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (lat == '0) begin
                    state_d = BURST;
                    present = 1'b1;
                end else begin
                    lat_d = lat - LAT_W'(1);
                end
            end
            BURST: begin
                if (bus.rready) begin
                    if (rlast) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        addr_d  = addr_next;
                        beat_d  = beat + 8'd1;
                        present = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_off = addr_d - ADDR_BASE;
        rd_hit = (addr_d >= ADDR_BASE) && (rd_off < SPAN);
        rd_idx = IDX_W'(rd_off >> 3);

        if (present) begin
            rvalid_d = 1'b1;
            rid_d    = id_d;
            rlast_d  = (beat_d == len_d);
            if (slverr_d) begin
                rresp_d = RESP_SLVERR;
                rdata_d = 64'd0;
            end else if (!rd_hit) begin
                rresp_d = RESP_DECERR;
                rdata_d = 64'd0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem[rd_idx];
            end
        end

        arready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= 32'd0;
            id      <= 4'd0;
            len     <= 8'd0;
            size    <= 3'd0;
            burst   <= 2'd0;
            slverr  <= 1'b0;
            beat    <= 8'd0;
            lat     <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= 64'd0;
            rid     <= 4'd0;
        end else begin
            state   <= state_d;
            addr    <= addr_d;
            id      <= id_d;
            len     <= len_d;
            size    <= size_d;
            burst   <= burst_d;
            slverr  <= slverr_d;
            beat    <= beat_d;
            lat     <= lat_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rresp   <= rresp_d;
            rdata   <= rdata_d;
            rid     <= rid_d;
        end
    end

    assign wr_off = mem_waddr - ADDR_BASE;
    assign wr_hit = (mem_waddr >= ADDR_BASE) && (wr_off < SPAN);
    assign wr_idx = IDX_W'(wr_off >> 3);

    // Byte-masked preload; a read on the same edge sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we && wr_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_wstrb[i]) mem[wr_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Randomized bench for axi_sram_read_slave against an arithmetic model of bursts and responses.
module tb_axi_sram_read_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mdl [DEPTH];
    logic [63:0] exp_data [256];
    logic [1:0]  exp_resp [256];

    axi_sram_read_slave_if bus ();

    axi_sram_read_slave #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < DEPTH * 8);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int unsigned idx;
        mem_we    = 1'b1;
        mem_waddr = a;
        mem_wdata = d;
        mem_wstrb = s;
        @(negedge clk);
        mem_we = 1'b0;
        if (in_range(a)) begin
            idx = (a - BASE) / 8;
            for (int i = 0; i < 8; i++) if (s[i]) mdl[idx][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    // Beat k address from burst arithmetic; response from the first matching rule.
    task automatic model_burst(input logic [31:0] a, input int len, input int size, input logic [1:0] bt);
        int unsigned step, w;
        logic [31:0] base, ba;
        bit bad;
        step = 1 << size;
        w    = (len + 1) * step;
        base = a - (a % w);
        bad  = (size > 3) || (bt == 2'b11)
            || ((bt == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15))
            || ((bt == 2'b10) && ((a % step) != 0));
        for (int k = 0; k <= len; k++) begin
            case (bt)
                2'b00:   ba = a;
                2'b10:   ba = base + ((a - base + k * step) % w);
                default: ba = a + k * step;
            endcase
            if (bad) begin
                exp_resp[k] = 2'b10;
                exp_data[k] = 64'd0;
            end else if (in_range(ba)) begin
                exp_resp[k] = 2'b00;
                exp_data[k] = mdl[(ba - BASE) / 8];
            end else begin
                exp_resp[k] = 2'b11;
                exp_data[k] = 64'd0;
            end
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt);
        int g = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = bt;
        while (!bus.arready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("ar_accept", 64'(bus.arready), 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("arready_drop", 64'(bus.arready), 64'd0);
    endtask

    // mode 0: rready always 1; 1: pattern 1,0,0,1; 2: random
    task automatic recv_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] bt, input int mode);
        int lat = 0, beat = 0, g = 0, ph = 0;
        bit rr;
        model_burst(a, int'(len), int'(size), bt);
        while (!bus.rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("first_latency", 64'(lat), 64'(LAT));
        while (beat <= int'(len) && g < 4000) begin
            g++;
            check("rvalid", 64'(bus.rvalid), 64'd1);
            if (!bus.rvalid) break;
            check("arready_busy", 64'(bus.arready), 64'd0);
            check("rid", 64'(bus.rid), 64'(id));
            check("rresp", 64'(bus.rresp), 64'(exp_resp[beat]));
            if (exp_resp[beat] != 2'b10) check("rdata", bus.rdata, exp_data[beat]);
            check("rlast", 64'(bus.rlast), 64'(beat == int'(len)));
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (ph % 4 == 0) || (ph % 4 == 3);
                default: rr = ($urandom_range(0, 9) < 7);
            endcase
            ph++;
            bus.rready = rr;
            @(negedge clk);
            if (rr) beat++;
        end
        bus.rready = 1'b0;
        check("beat_count", 64'(beat), 64'(int'(len) + 1));
        check("rvalid_after", 64'(bus.rvalid), 64'd0);
        check("arready_turn", 64'(bus.arready), 64'd1);
    endtask

    task automatic do_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] bt, input int mode);
        send_ar(a, id, len, size, bt);
        recv_burst(a, id, len, size, bt, mode);
    endtask

    initial begin
        int g;
        rst         = 1'b1;
        mem_we      = 1'b0;
        mem_waddr   = 32'd0;
        mem_wdata   = 64'd0;
        mem_wstrb   = 8'd0;
        bus.arvalid = 1'b0;
        bus.araddr  = 32'd0;
        bus.arid    = 4'd0;
        bus.arlen   = 8'd0;
        bus.arsize  = 3'd0;
        bus.arburst = 2'd0;
        bus.rready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_rlast", 64'(bus.rlast), 64'd0);
        check("rst_rresp", 64'(bus.rresp), 64'd0);
        check("rst_rid", 64'(bus.rid), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        rst = 1'b0;
        #1;
        check("arready_before_edge", 64'(bus.arready), 64'd0);
        @(negedge clk);
        check("arready_rise", 64'(bus.arready), 64'd1);

        for (int i = 0; i < int'(DEPTH); i++) preload(BASE + 32'(i * 8), {$urandom, $urandom}, 8'hFF);

        preload(BASE + 32'h10, 64'hA5A5_0002, 8'hFF);
        do_burst(32'h8000_0010, 4'd0, 8'd0, 3'd3, 2'b01, 0);
        for (int k = 0; k < 4; k++) preload(BASE + 32'(k * 8), 64'(k), 8'hFF);
        do_burst(BASE, 4'd1, 8'd3, 3'd3, 2'b01, 1);
        do_burst(BASE + 32'h10, 4'd2, 8'd3, 3'd3, 2'b10, 0);
        do_burst(32'h7FFF_FFF0, 4'd3, 8'd1, 3'd3, 2'b01, 2);
        do_burst(BASE, 4'd4, 8'd2, 3'd3, 2'b10, 0);
        do_burst(BASE + 32'h8, 4'd4, 8'd3, 3'd3, 2'b10, 0);

        // byte strobes, and writes just outside the array must not alias into it
        preload(BASE + 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        preload(BASE + 32'(DEPTH * 8), 64'hDEAD_BEEF_0000_0001, 8'hFF);
        preload(BASE - 32'd8, 64'hDEAD_BEEF_0000_0002, 8'hFF);
        do_burst(BASE, 4'd5, 8'd1, 3'd3, 2'b01, 0);
        do_burst(BASE + 32'(DEPTH * 8) - 32'd16, 4'd6, 8'd3, 3'd3, 2'b01, 2);
        do_burst(BASE + 32'd40, 4'd6, 8'd3, 3'd3, 2'b00, 2);
        do_burst(BASE + 32'd4, 4'd7, 8'd3, 3'd2, 2'b01, 2);

        // reset during the second beat of an 8-beat burst
        send_ar(BASE, 4'd8, 8'd7, 3'd3, 2'b01);
        g = 0;
        while (!bus.rvalid && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("mid_rvalid", 64'(bus.rvalid), 64'd1);
        check("mid_rlast", 64'(bus.rlast), 64'd0);
        rst = 1'b1;
        #1;
        check("abort_rvalid", 64'(bus.rvalid), 64'd0);
        check("abort_arready", 64'(bus.arready), 64'd0);
        check("abort_rlast", 64'(bus.rlast), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("release_arready", 64'(bus.arready), 64'd0);
        @(negedge clk);
        check("release_arready_rise", 64'(bus.arready), 64'd1);
        do_burst(BASE + 32'd64, 4'd9, 8'd3, 3'd3, 2'b01, 0);

        // second request held on AR while the first burst runs
        send_ar(BASE + 32'd80, 4'hA, 8'd3, 3'd3, 2'b01);
        bus.arvalid = 1'b1;
        bus.araddr  = BASE + 32'd160;
        bus.arid    = 4'h5;
        bus.arlen   = 8'd1;
        bus.arsize  = 3'd3;
        bus.arburst = 2'b01;
        recv_burst(BASE + 32'd80, 4'hA, 8'd3, 3'd3, 2'b01, 2);
        send_ar(BASE + 32'd160, 4'h5, 8'd1, 3'd3, 2'b01);
        recv_burst(BASE + 32'd160, 4'h5, 8'd1, 3'd3, 2'b01, 0);

        for (int t = 0; t < 60; t++) begin
            logic [1:0]  bt;
            logic [2:0]  sz;
            logic [7:0]  ln;
            logic [31:0] a;
            int          r;
            r  = $urandom_range(0, 9);
            bt = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
            sz = ($urandom_range(0, 9) < 7) ? 3'd3 : 3'($urandom_range(0, 7));
            if (bt == 2'b10 && $urandom_range(0, 4) != 0) ln = 8'((2 << $urandom_range(0, 3)) - 1);
            else ln = 8'($urandom_range(0, 15));
            a = BASE + (32'($urandom_range(0, DEPTH * 8 - 1)) & ~((32'd1 << sz) - 32'd1));
            r = $urandom_range(0, 9);
            if (r == 0) a = BASE - 32'($urandom_range(1, 8)) * 32'd8;
            else if (r == 1) a = BASE + 32'(DEPTH * 8) - 32'($urandom_range(1, 4)) * 32'd8;
            do_burst(a, 4'($urandom), ln, sz, bt, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
